// File: rtl/share_encoder_if.sv
// Valid/ready stream bundle carrying unmasked words in and the two Boolean shares out.
interface share_encoder_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] share0;
  logic [WIDTH-1:0] share1;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, share0, share1, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, share0, share1, out_valid
  );
endinterface

// File: rtl/share_encoder.sv
// Two-share Boolean masking front end: share0 = data ^ m, share1 = m, both registered.
// Define SHARE_ENC_LFSR_EN for an internal seeded LFSR mask source; otherwise m comes from rnd_in.
module share_encoder #(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] LFSR_TAPS    = 64'hD800000000000000,
  parameter int               RESEED_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  share_encoder_if.slave   bus,
`ifdef SHARE_ENC_LFSR_EN
  input  logic [WIDTH-1:0] seed_in,
  input  logic             seed_valid,
  output logic             reseed_req
`else
  input  logic [WIDTH-1:0] rnd_in,
  input  logic             rnd_valid,
  output logic             rnd_ready
`endif
);

  if (RESEED_LIMIT < 1 || LFSR_TAPS == '0) begin : g_cfg_err
    $error("share_encoder: RESEED_LIMIT must be >= 1 and LFSR_TAPS nonzero");
  end

  logic [WIDTH-1:0] m;
  logic             rdy;
  logic             acc;
  logic             room;
  logic             pop;
  logic [WIDTH-1:0] share0_p1;
  logic [WIDTH-1:0] share1_p1;
  logic             vld_p1;

  assign pop  = vld_p1 & bus.out_ready;
  assign room = ~vld_p1 | bus.out_ready;
  assign acc  = bus.in_valid & rdy;

`ifdef SHARE_ENC_LFSR_EN
  localparam int CNT_W = $clog2(RESEED_LIMIT + 1);

  typedef enum logic {NEED_SEED, RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] lfsr;
  logic [CNT_W-1:0] cnt;
  logic             last;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ^(v & LFSR_TAPS)};
  endfunction

  assign m    = lfsr;
  assign last = (cnt == CNT_W'(RESEED_LIMIT - 1));

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
      cnt  <= '0;
    end else if (seed_valid) begin
      lfsr <= (seed_in == '0) ? WIDTH'(1) : seed_in;
      cnt  <= '0;
    end else if (acc) begin
      lfsr <= lfsr_step(lfsr);
      cnt  <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NEED_SEED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rdy        = 1'b0;
    reseed_req = 1'b0;
    case (state)
      NEED_SEED: reseed_req = 1'b1;
      RUN:       rdy        = room & ~seed_valid;
      default:   reseed_req = 1'b1;
    endcase
    if (seed_valid)                    state_nxt = RUN;
    else if (bus.in_valid & rdy & last) state_nxt = NEED_SEED;
  end
`else
  assign m         = rnd_in;
  assign rdy       = room & rnd_valid;
  assign rnd_ready = acc;
`endif

  // Output stage: the only point where in_data and m meet is the share0 flop input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      share0_p1 <= '0;
      share1_p1 <= '0;
      vld_p1    <= 1'b0;
    end else if (acc) begin
      share0_p1 <= bus.in_data ^ m;
      share1_p1 <= m;
      vld_p1    <= 1'b1;
    end else if (pop) begin
      vld_p1    <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.share0    = share0_p1;
  assign bus.share1    = share1_p1;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_share_encoder.sv
// Scoreboard bench for share_encoder; follows SHARE_ENC_LFSR_EN to pick the mask-source variant.
module tb_share_encoder;
  localparam int             W     = 8;
  localparam logic [W-1:0]   TAPS  = 8'hB8;
  localparam int             LIMIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  share_encoder_if #(.WIDTH(W)) bus ();

  // aux_* map to seed_in/seed_valid/reseed_req or rnd_in/rnd_valid/rnd_ready
  logic [W-1:0] aux_data;
  logic         aux_valid;
  logic         aux_flag;

  share_encoder #(.WIDTH(W), .LFSR_TAPS(TAPS), .RESEED_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
`ifdef SHARE_ENC_LFSR_EN
    .seed_in    (aux_data),
    .seed_valid (aux_valid),
    .reseed_req (aux_flag)
`else
    .rnd_in    (aux_data),
    .rnd_valid (aux_valid),
    .rnd_ready (aux_flag)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic [W-1:0] d;
  } exp_t;

  exp_t q[$];
  exp_t e;

  logic [W-1:0] ref_mask;
  int           ref_uses;
  bit           ref_need_seed;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

`ifdef SHARE_ENC_LFSR_EN
  function automatic logic [W-1:0] next_mask(input logic [W-1:0] v);
    return W'(v * 2) + W'($countones(v & TAPS) % 2);
  endfunction
`endif

  function automatic void reset_model();
    ref_mask      = '0;
    ref_uses      = 0;
    ref_need_seed = 1'b1;
    q.delete();
  endfunction

  // One clock of stimulus: inputs change just after posedge, control is checked before the next one.
  task automatic drive(input bit iv, input logic [W-1:0] d, input bit av,
                       input logic [W-1:0] a, input bit ordy);
    bit room;
    bit rdy_exp;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    aux_valid     = av;
    aux_data      = a;
    @(negedge clk);
    #1;
    room = (q.size() == 0) || ordy;
`ifdef SHARE_ENC_LFSR_EN
    rdy_exp = !ref_need_seed && !av && room;
    chk("reseed_req", W'(aux_flag), W'(ref_need_seed));
`else
    rdy_exp = av && room;
    chk("rnd_ready", W'(aux_flag), W'(iv && rdy_exp));
`endif
    chk("in_ready", W'(bus.in_ready), W'(rdy_exp));
    if (iv && rdy_exp) begin
`ifdef SHARE_ENC_LFSR_EN
      q.push_back('{s0: d ^ ref_mask, s1: ref_mask, d: d});
      ref_mask = next_mask(ref_mask);
      ref_uses++;
      if (ref_uses == LIMIT) ref_need_seed = 1'b1;
`else
      q.push_back('{s0: d ^ a, s1: a, d: d});
`endif
    end
`ifdef SHARE_ENC_LFSR_EN
    if (av) begin
      ref_mask      = (a == '0) ? W'(1) : a;
      ref_uses      = 0;
      ref_need_seed = 1'b0;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  bit           held = 1'b0;
  logic [W-1:0] held_s0;
  logic [W-1:0] held_s1;

  // Monitor: out_valid tracks scoreboard occupancy, stalled shares stay put, every pop is compared.
  always @(negedge clk) begin
    if (!rst_n) begin
      held <= 1'b0;
    end else begin
      chk("out_valid", W'(bus.out_valid), W'(q.size() != 0));
      if (held) begin
        chk("hold_share0", bus.share0, held_s0);
        chk("hold_share1", bus.share1, held_s1);
      end
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("share0", bus.share0, e.s0);
        chk("share1", bus.share1, e.s1);
        chk("recombine", bus.share0 ^ bus.share1, e.d);
      end
      held    <= bus.out_valid && !bus.out_ready;
      held_s0 <= bus.share0;
      held_s1 <= bus.share1;
    end
  end

  task automatic random_phase(input int n);
    bit av;
    for (int i = 0; i < n; i++) begin
`ifdef SHARE_ENC_LFSR_EN
      av = ref_need_seed ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
      drive($urandom_range(3) != 0, W'($urandom), av,
            ($urandom_range(3) == 0) ? W'(0) : W'($urandom), $urandom_range(3) != 0);
`else
      av = $urandom_range(3) != 0;
      drive($urandom_range(3) != 0, W'($urandom), av, W'($urandom), $urandom_range(3) != 0);
`endif
    end
  endtask

  task automatic async_reset_check();
    drive(1'b1, W'($urandom), 1'b1, W'($urandom), 1'b0);
    bus.in_valid = 1'b0;
    aux_valid    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_share0", bus.share0, W'(0));
    chk("rst_share1", bus.share1, W'(0));
    reset_model();
    #4;
    rst_n = 1'b1;
    #1;
    chk("post_rst_out_valid", W'(bus.out_valid), W'(0));
`ifdef SHARE_ENC_LFSR_EN
    chk("post_rst_reseed_req", W'(aux_flag), W'(1));
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    aux_valid     = 1'b0;
    aux_data      = '0;
    reset_model();
    #1;
    chk("reset_out_valid", W'(bus.out_valid), W'(0));
    chk("reset_share0", bus.share0, W'(0));
    chk("reset_share1", bus.share1, W'(0));
    chk("reset_in_ready", W'(bus.in_ready), W'(0));
`ifdef SHARE_ENC_LFSR_EN
    chk("reset_reseed_req", W'(aux_flag), W'(1));
`endif
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef SHARE_ENC_LFSR_EN
    drive(1'b0, W'(0), 1'b1, 8'h01, 1'b1);
    drive(1'b1, 8'hA5, 1'b0, W'(0), 1'b1);
    chk("t1_a_share0", bus.share0, 8'hA4);
    chk("t1_a_share1", bus.share1, 8'h01);
    drive(1'b1, 8'hFF, 1'b0, W'(0), 1'b1);
    chk("t1_b_share0", bus.share0, 8'hFD);
    chk("t1_b_share1", bus.share1, 8'h02);
    drive(1'b1, 8'h77, 1'b0, W'(0), 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, W'($urandom), 1'b0, W'(0), 1'b0);
    drive(1'b1, 8'h5C, 1'b0, W'(0), 1'b1);
    chk("t3_reseed_req", W'(aux_flag), W'(1));
    drive(1'b1, 8'h99, 1'b0, W'(0), 1'b1);
    drive(1'b1, 8'h42, 1'b1, 8'h00, 1'b1);
    drive(1'b1, 8'h5A, 1'b0, W'(0), 1'b1);
    chk("t3_zero_seed_share1", bus.share1, 8'h01);
    chk("t3_zero_seed_share0", bus.share0, 8'h5B);
    drive(1'b1, 8'h33, 1'b1, 8'hC3, 1'b1);
    drive(1'b1, 8'h11, 1'b0, W'(0), 1'b1);
    chk("t4_seed_share1", bus.share1, 8'hC3);
    chk("t4_seed_share0", bus.share0, 8'hD2);
`else
    drive(1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1);
    drive(1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1);
    chk("t5_share0", bus.share0, 8'h00);
    chk("t5_share1", bus.share1, 8'h3C);
    drive(1'b0, W'(0), 1'b0, W'(0), 1'b1);
    drive(1'b1, 8'h81, 1'b1, 8'h18, 1'b1);
    chk("t2_share0", bus.share0, 8'h99);
    for (int i = 0; i < 3; i++) drive(1'b1, W'($urandom), 1'b1, W'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, W'($urandom), 1'b1, W'($urandom), 1'b1);
`endif

    random_phase(400);
    async_reset_check();
`ifdef SHARE_ENC_LFSR_EN
    drive(1'b0, W'(0), 1'b1, W'($urandom), 1'b1);
`endif
    random_phase(60);
    for (int i = 0; i < 3; i++) drive(1'b0, W'(0), 1'b0, W'(0), 1'b1);
    chk("drain_empty", W'(q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
